// File: rtl/epu_alg_pkg.sv
// epu_alg_pkg: shared sample, block and bank-state types for the EPU_ALG pixel path
package epu_alg_pkg;
  localparam int DATA_W = 8;
  localparam int BLK = 8;
  localparam int LANES = 4;
  typedef logic [DATA_W-1:0] pix_t;
  typedef pix_t [BLK-1:0][BLK-1:0] blk_t;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_e;
endpackage

// File: rtl/ycrcb_bank.sv
// ycrcb_bank: BLK x BLK sample store written one LANES-wide column group per cycle
module ycrcb_bank #(
  parameter int DATA_W = 8,
  parameter int BLK = 8,
  parameter int LANES = 4,
  parameter int RW = 3,
  parameter int CW = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  we,
  input  logic [RW-1:0]                         row,
  input  logic [CW-1:0]                         colgrp,
  input  logic [LANES-1:0][DATA_W-1:0]          wdata,
  output logic [BLK-1:0][BLK-1:0][DATA_W-1:0]   q
);
  import epu_alg_pkg::*;
  localparam int LW = LANES * DATA_W;
  localparam int ROW_W = BLK * DATA_W;
  logic [BLK-1:0][BLK-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [ROW_W-1:0] mask, lane_bits;
  // lane 0 sits in the low bits of a row, so a column group is a shifted lane vector
  always_comb begin
    mask = ROW_W'({LW{1'b1}}) << (int'(colgrp) * LW);
    lane_bits = ROW_W'(wdata) << (int'(colgrp) * LW);
    mem_d = mem_q;
    if (we) mem_d[row] = (mem_q[row] & ~mask) | lane_bits;
  end
  always_ff @(posedge clk) mem_q <= rst ? '0 : mem_d;
  assign q = mem_q;
endmodule

// File: rtl/ycrcb_block_buf.sv
// ycrcb_block_buf: ping-pong assembler turning LANES-wide pixel beats into BLK x BLK blocks
module ycrcb_block_buf #(
  parameter int DATA_W = epu_alg_pkg::DATA_W,
  parameter int BLK = epu_alg_pkg::BLK,
  parameter int LANES = epu_alg_pkg::LANES,
  localparam int BPR = BLK / LANES,
  localparam int BPB = BLK * BPR,
  localparam int BW = $clog2(BPB) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [LANES-1:0][DATA_W-1:0]          in_data,
  input  logic                                  flush,
  output logic                                  blk_valid,
  input  logic                                  blk_release,
  output logic [BLK-1:0][BLK-1:0][DATA_W-1:0]   blk_data,
  output logic                                  blk_bank,
  output logic [BW-1:0]                         fill_cnt
);
  import epu_alg_pkg::*;
  localparam int RW = BLK > 1 ? $clog2(BLK) : 1;
  localparam int CW = BPR > 1 ? $clog2(BPR) : 1;
  if (BLK % LANES != 0) begin : g_lanes_chk
    $error("LANES must divide BLK");
  end
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] full_q, full_d, we;
  logic [BW-1:0] beat_q, beat_d;
  logic accept, last, rel;
  logic [RW-1:0] row;
  logic [CW-1:0] colgrp;
  bank_st_e bank_st [2];
  logic [BLK-1:0][BLK-1:0][DATA_W-1:0] bank_q [2];
  always_comb begin
    for (int b = 0; b < 2; b++)
      bank_st[b] = full_q[b] ? FULL : (b == int'(wr_ptr_q) && beat_q != '0) ? FILLING : EMPTY;
    in_ready = bank_st[wr_ptr_q] != FULL;
    blk_valid = bank_st[rd_ptr_q] == FULL;
    accept = in_valid && in_ready && !flush;
    last = beat_q == BW'(BPB - 1);
    rel = blk_release && blk_valid;
    // a release and a completion never hit the same bank: the write bank is never full
    full_d = (full_q & ~(2'(rel) << rd_ptr_q)) | (2'(accept && last) << wr_ptr_q);
    beat_d = (flush || (accept && last)) ? '0 : beat_q + BW'(accept);
    wr_ptr_d = wr_ptr_q ^ (accept && last);
    rd_ptr_d = rd_ptr_q ^ rel;
    we = 2'(accept) << wr_ptr_q;
    row = RW'(int'(beat_q) / BPR);
    colgrp = CW'(int'(beat_q) % BPR);
    blk_data = bank_q[rd_ptr_q];
    blk_bank = rd_ptr_q;
    fill_cnt = beat_q;
  end
  always_ff @(posedge clk) begin
    wr_ptr_q <= rst ? 1'b0 : wr_ptr_d;
    rd_ptr_q <= rst ? 1'b0 : rd_ptr_d;
    full_q <= rst ? 2'b00 : full_d;
    beat_q <= rst ? '0 : beat_d;
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    ycrcb_bank #(
      .DATA_W(DATA_W), .BLK(BLK), .LANES(LANES), .RW(RW), .CW(CW)
    ) u_bank (
      .clk(clk), .rst(rst), .we(we[b]), .row(row), .colgrp(colgrp),
      .wdata(in_data), .q(bank_q[b])
    );
  end
endmodule

// File: tb/tb_ycrcb_block_buf.sv
// tb_ycrcb_block_buf: directed scenarios with an expected-block queue popped on every release
module tb_ycrcb_block_buf;
  import epu_alg_pkg::*;
  localparam int BPR = BLK / LANES;
  localparam int BPB = BLK * BPR;
  typedef struct {blk_t d; logic b;} exp_t;
  logic clk = 0, rst = 0, in_valid = 0, flush = 0, blk_release = 0;
  logic in_ready, blk_valid, blk_bank;
  logic [LANES-1:0][DATA_W-1:0] in_data = '0;
  blk_t blk_data;
  logic [$clog2(BPB):0] fill_cnt;
  int checks = 0, errors = 0, pops = 0, cyc = 0;
  int mb = 0;
  logic mwr = 0;
  blk_t mdl = '0;
  exp_t sb[$];
  ycrcb_block_buf dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .blk_valid(blk_valid), .blk_release(blk_release), .blk_data(blk_data),
    .blk_bank(blk_bank), .fill_cnt(fill_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // monitor: a block leaves the buffer on the edge following blk_valid && blk_release
  always @(negedge clk) begin
    if (!rst && blk_valid && blk_release) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL blk_pop: block released with empty scoreboard, bank %0d", blk_bank);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        if (blk_data !== e.d || blk_bank !== e.b) begin
          errors++;
          $display("FAIL blk_pop: got bank %0d data %h expected bank %0d data %h", blk_bank, blk_data, e.b, e.d);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_beat(input logic [7:0] base, input int k, input logic fl);
    int n;
    logic acc;
    n = 0;
    in_valid = 1;
    flush = fl;
    for (int m = 0; m < LANES; m++) in_data[m] = base + 8'(LANES * k + m);
    while (!in_ready && !fl && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("beat_wait_timeout", 1, 0);
    acc = in_ready && !fl;
    tick();
    in_valid = 0;
    flush = 0;
    if (fl) mb = 0;
    if (acc) begin
      for (int m = 0; m < LANES; m++) mdl[mb / BPR][(mb % BPR) * LANES + m] = base + 8'(LANES * k + m);
      mb++;
      if (mb == BPB) begin
        sb.push_back('{d: mdl, b: mwr});
        mwr = ~mwr;
        mb = 0;
      end
    end
  endtask
  task automatic send_block(input logic [7:0] base);
    for (int k = 0; k < BPB; k++) send_beat(base, k, 1'b0);
  endtask
  task automatic release_blk();
    blk_release = 1;
    tick();
    blk_release = 0;
  endtask
  task automatic do_reset(input string nm);
    rst = 1;
    in_valid = 0;
    flush = 0;
    blk_release = 0;
    tick();
    chk({nm, "_blk_valid"}, int'(blk_valid), 0);
    chk({nm, "_blk_bank"}, int'(blk_bank), 0);
    chk({nm, "_blk_data_zero"}, int'(blk_data == '0), 1);
    chk({nm, "_fill_cnt"}, int'(fill_cnt), 0);
    chk({nm, "_in_ready"}, int'(in_ready), 1);
    rst = 0;
    sb.delete();
    mb = 0;
    mwr = 0;
    mdl = '0;
  endtask
  initial begin
    int c0, p0;
    blk_t t1;
    // T1: data pattern 8r+c
    do_reset("t1_rst");
    for (int r = 0; r < BLK; r++) for (int c = 0; c < BLK; c++) t1[r][c] = 8'(8 * r + c);
    send_block(8'h00);
    chk("t1_blk_valid", int'(blk_valid), 1);
    chk("t1_fill_cnt", int'(fill_cnt), 0);
    chk("t1_data", int'(blk_data == t1), 1);
    release_blk();
    chk("t1_valid_after_rel", int'(blk_valid), 0);
    // T2: both banks fill, then stall
    do_reset("t2_rst");
    send_block(8'h10);
    send_block(8'h20);
    in_valid = 1;
    for (int m = 0; m < LANES; m++) in_data[m] = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      chk("t2_in_ready_stall", int'(in_ready), 0);
      tick();
    end
    in_valid = 0;
    chk("t2_fill_cnt_stall", int'(fill_cnt), 0);
    chk("t2_bank_before", int'(blk_bank), 0);
    release_blk();
    chk("t2_bank_after", int'(blk_bank), 1);
    chk("t2_in_ready_after", int'(in_ready), 1);
    chk("t2_valid_after", int'(blk_valid), 1);
    release_blk();
    chk("t2_valid_empty", int'(blk_valid), 0);
    // T3: streaming with prompt release
    do_reset("t3_rst");
    c0 = cyc;
    p0 = pops;
    fork
      for (int b = 0; b < 4; b++)
        for (int k = 0; k < BPB; k++) begin
          chk("t3_in_ready", int'(in_ready), 1);
          send_beat(8'(8'h40 * b + 8'h03), k, 1'b0);
        end
      begin
        logic prev;
        prev = 0;
        repeat (68) begin
          tick();
          blk_release = blk_valid && !prev;
          prev = blk_valid;
        end
        blk_release = 0;
      end
    join
    chk("t3_beats_cycles", 0, 0 + ((cyc - c0) < 64 ? 1 : 0));
    chk("t3_blocks", pops - p0, 4);
    // T4: flush drops partial block and the same-cycle beat
    do_reset("t4_rst");
    for (int k = 0; k < 5; k++) send_beat(8'hA0, k, 1'b0);
    chk("t4_fill_5", int'(fill_cnt), 5);
    send_beat(8'hA0, 5, 1'b1);
    chk("t4_fill_flush", int'(fill_cnt), 0);
    send_block(8'h60);
    chk("t4_blk_valid", int'(blk_valid), 1);
    release_blk();
    // T5: edge cases
    do_reset("t5_rst");
    for (int k = 0; k < BPB - 1; k++) send_beat(8'h70, k, 1'b0);
    send_beat(8'h70, BPB - 1, 1'b1);
    chk("t5_flush_last_valid", int'(blk_valid), 0);
    chk("t5_flush_last_fill", int'(fill_cnt), 0);
    release_blk();
    chk("t5_idle_rel_bank", int'(blk_bank), 0);
    chk("t5_idle_rel_valid", int'(blk_valid), 0);
    for (int k = 0; k < 3; k++) send_beat(8'h90, k, 1'b0);
    release_blk();
    chk("t5_idle_rel_fill", int'(fill_cnt), 3);
    chk("t5_idle_rel_ready", int'(in_ready), 1);
    do_reset("t5b_rst");
    send_block(8'h11);
    for (int k = 0; k < BPB - 1; k++) send_beat(8'h22, k, 1'b0);
    blk_release = 1;
    send_beat(8'h22, BPB - 1, 1'b0);
    blk_release = 0;
    chk("t5_both_valid", int'(blk_valid), 1);
    chk("t5_both_bank", int'(blk_bank), 1);
    chk("t5_both_ready", int'(in_ready), 1);
    chk("t5_both_fill", int'(fill_cnt), 0);
    release_blk();
    chk("t5_both_empty", int'(blk_valid), 0);
    // T6: reset mid-block with bank 1 full
    do_reset("t6_rst0");
    send_block(8'h01);
    release_blk();
    send_block(8'h80);
    for (int k = 0; k < 9; k++) send_beat(8'h33, k, 1'b0);
    chk("t6_fill_9", int'(fill_cnt), 9);
    chk("t6_bank1", int'(blk_bank), 1);
    do_reset("t6_rst");
    send_block(8'h55);
    chk("t6_new_bank", int'(blk_bank), 0);
    chk("t6_new_valid", int'(blk_valid), 1);
    release_blk();
    chk("t6_sb_empty", sb.size(), 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
